truth_table_scanner: RTL
========================

# truth_table_scanner

Sequential truth-table reader for the gate-exercise modules. Instead of a hand-written initial block, it sweeps every input combination onto two candidate implementations of the same Boolean function, such as a gate-level and an expression-level version. At each combination it samples their outputs, assembles each implementation's minterm mask, and reports where the two disagree. It sits between a stimulus-free top level and the two function instances, and replaces the manual $monitor comparison.

## Interface
Parameters:
- N, default 2: number of function inputs; legal range 1..4; the mask width is M = 2^N.
- SETTLE, default 1: cycles the stimulus is held before sampling; minimum 1.

Ports:
- clock  input  1  — single clock; all logic is on the rising edge.
- reset  input  1  — synchronous, active-high.
- start  input  1  — request a scan; accepted only in IDLE.
- stim  output  N  — input vector driven to both implementations; stim[N-1] is the leftmost variable (a).
- resp_a  input  1  — output of implementation A.
- resp_b  input  1  — output of implementation B.
- busy  output  1  — high from start acceptance until the state leaves SAMPLE for the last time.
- done  output  1  — one-cycle pulse when results are valid.
- mask_a  output  M  — bit m = resp_a sampled with stim == m.
- mask_b  output  M  — the same for resp_b.
- diff  output  M  — mask_a XOR mask_b.
- equal  output  1  — 1 when diff == 0.
- ones_a  output  N+1  — population count of mask_a.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 clears mask_a, mask_b and the settle counter, sets stim to 0, and moves to DRIVE.
  - start=0 stays in IDLE and holds the previous results.
- DRIVE:
  - Holds stim for SETTLE cycles using the counter, then moves to SAMPLE.
- SAMPLE:
  - At the edge leaving SAMPLE, writes resp_a into mask_a[stim] and resp_b into mask_b[stim].
  - If stim == M-1, moves to DONE.
  - Otherwise increments stim, clears the counter, and returns to DRIVE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
- start is ignored in DRIVE, SAMPLE and DONE. No queuing.
- diff, equal and ones_a are combinational from the mask registers. They are valid and stable from the DONE cycle until the next accepted start.
- stim does not wrap: it holds M-1 through DONE and IDLE until the next start.
- Reset values: state IDLE, stim 0, busy 0, done 0, mask_a 0, mask_b 0. This gives diff 0, equal 1, ones_a 0.
- Reset asserted mid-scan aborts the scan immediately at the next edge and applies the reset values. No done pulse is produced.
- reset and start asserted together: reset wins.

## Timing
- Start accepted at edge k: busy=1 and stim=0 from cycle k+1.
- Each minterm takes SETTLE+1 cycles.
- done is high in cycle k+1+M·(SETTLE+1). With defaults (N=2, SETTLE=1) that is k+9.
- The bit for minterm m is sampled at the end of the last cycle of its SAMPLE state, so the responses see stim stable for SETTLE+1 cycles.
- Back-to-back scans: a start during the DONE cycle is ignored. The earliest accepted start is in the first IDLE cycle after DONE.

## Structure
Shared package `truth_table_pkg` holds:
- the state enum (IDLE, DRIVE, SAMPLE, DONE);
- the N and SETTLE range constants;
- a function returning M for a given N.

One sub-module is natural: `popcount_m`, a combinational count of ones over an M-bit vector, used for ones_a.

## Test plan
- Function a'·b on resp_a, and nand on resp_b, defaults: after start, done at +9 cycles with mask_a=0010, mask_b=0111, diff=0101, equal=0, ones_a=1.
- Two identical a'·b instances: mask_a=mask_b=0010, diff=0000, equal=1.
- Reset asserted in the cycle after the third SAMPLE: next cycle shows busy=0, stim=0, masks 0, and no done pulse. A new start then completes normally.
- start held high through an entire scan and during DONE: exactly one done pulse, and the next scan begins on the first IDLE cycle.
- Parameters N=3, SETTLE=2, resp_a = majority(stim): done at +25 cycles, mask_a=11101000, ones_a=4.
- Responses that change while the stimulus settles (resp_a toggled during DRIVE and stable during SAMPLE): only the value sampled at the end of SAMPLE is recorded.

Source files
------------

// File: rtl/truth_table_pkg.sv
// ============================================================================
// Module      : truth_table_pkg
// Description : Shared types and constants for the truth-table scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int N_MIN      = 1;
    localparam int N_MAX      = 4;
    localparam int SETTLE_MIN = 1;

    // Number of minterms (mask bits) for an n-input function.
    function automatic int mask_width(input int n);
        return 1 << n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/popcount_m.sv
// ============================================================================
// Module      : popcount_m
// Description : Combinational population count over a W-bit vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_m #(
    parameter int W  = 4,
    parameter int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_vec,
    output logic [OW-1:0] o_count
);

    logic [OW-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < W; i++) begin
            w_sum = w_sum + OW'(i_vec[i]);
        end
    end

    assign o_count = w_sum;

endmodule

`default_nettype wire

// File: rtl/truth_table_scanner.sv
// ============================================================================
// Module      : truth_table_scanner
// Description : Sweeps all input combinations onto two implementations of a
//               Boolean function and records/compares their minterm masks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_scanner
    import truth_table_pkg::*;
#(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic [N-1:0]             stim,
    input  logic                     resp_a,
    input  logic                     resp_b,
    output logic                     busy,
    output logic                     done,
    output logic [mask_width(N)-1:0] mask_a,
    output logic [mask_width(N)-1:0] mask_b,
    output logic [mask_width(N)-1:0] diff,
    output logic                     equal,
    output logic [N:0]               ones_a
);

    localparam int M  = mask_width(N);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0] c_CNT_LAST  = CW'(SETTLE - 1);
    localparam logic [N-1:0]  c_STIM_LAST = N'(M - 1);

    state_t        r_state;
    logic [N-1:0]  r_stim;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [M-1:0]  r_mask_a;
    logic [M-1:0]  r_mask_b;
    logic [M-1:0]  w_diff;
    logic [N:0]    w_ones_a;

    // The counter runs 0..SETTLE-1 in DRIVE; SAMPLE adds one more cycle, so
    // each minterm occupies SETTLE+1 cycles with the stimulus held constant.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_stim   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mask_a <= '0;
            r_mask_b <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mask_a <= '0;
                        r_mask_b <= '0;
                        r_cnt    <= '0;
                        r_stim   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_SAMPLE: begin
                    r_mask_a[r_stim] <= resp_a;
                    r_mask_b[r_stim] <= resp_b;
                    if (r_stim == c_STIM_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_stim  <= r_stim + N'(1);
                        r_cnt   <= '0;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_diff = r_mask_a ^ r_mask_b;

    popcount_m #(
        .W  (M),
        .OW (N + 1)
    ) u_popcount_a (
        .i_vec   (r_mask_a),
        .o_count (w_ones_a)
    );

    assign stim   = r_stim;
    assign busy   = r_busy;
    assign done   = r_done;
    assign mask_a = r_mask_a;
    assign mask_b = r_mask_b;
    assign diff   = w_diff;
    assign equal  = (w_diff == '0);
    assign ones_a = w_ones_a;

endmodule

`default_nettype wire
